zvc_line_streamer: RTL and testbench
====================================

Name: zvc_line_streamer

Overview:
- Downstream consumer of the zero-value compressor.
- Accepts one compressed line (non-zero words packed at low indices, with mapping-table entries alongside) and serialises it into one word per beat for the PE array.
- Uses a valid/ready handshake on both sides.
- Zero-word tail is never emitted; an all-zero line produces no beats.

Parameters:
- WORD_WIDTH, 8, bits per activation word
- LINE_SIZE, 128, words per line
- DIST_WIDTH, 7, bits per mapping-table distance field
- MAX_LIFM_RSIZ, 4, distance fields per mapping-table entry
- IDX_WIDTH, 7, index width, equals clog2(LINE_SIZE)
- CNT_WIDTH, 8, count width, equals clog2(LINE_SIZE+1)

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- line_valid  in  1  compressed line present
- line_ready  out  1  streamer can accept a line
- lifm_comp  in  LINE_SIZE*WORD_WIDTH  compressed words; word i at [i*WORD_WIDTH+:WORD_WIDTH]
- mt_comp  in  LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ  mapping entries; entry i at [i*DIST_WIDTH*MAX_LIFM_RSIZ+:DIST_WIDTH*MAX_LIFM_RSIZ]
- out_valid  out  1  beat valid
- out_ready  in  1  consumer accepts beat
- out_word  out  WORD_WIDTH  current non-zero word
- out_mt  out  DIST_WIDTH*MAX_LIFM_RSIZ  mapping entry of current word
- out_idx  out  IDX_WIDTH  position of word in compressed line
- out_last  out  1  final beat of line
- line_done  out  1  one-cycle pulse, line fully consumed

Behaviour:
- Clock and reset: single clock clk; reset_n is synchronous and active-low.
- Reset: state=IDLE; idx=0, nz_cnt=0; out_valid, out_last and line_done =0; out_word, out_mt and out_idx =0; line/mt registers cleared. Reset mid-stream discards the line with no further beats, and line_ready=1 in the cycle after reset is released.
- States are IDLE and STREAM.
- IDLE:
  - line_ready=1 and out_valid=0.
  - On line_valid&&line_ready: register lifm_comp and mt_comp, and set nz_cnt = length of the leading non-zero prefix (index of the first zero word, or LINE_SIZE if none).
  - Words after the first zero are ignored; the compressor guarantees packing.
  - If nz_cnt==0: remain IDLE and pulse line_done in the next cycle.
  - Else: go to STREAM with idx=0.
- STREAM:
  - line_ready=0, so there is no line overlap.
  - out_valid=1; out_word=word[idx], out_mt=mt[idx], out_idx=idx, out_last=(idx==nz_cnt-1).
  - All outputs are registered or driven from registered state.
- Latency: line accepted at edge k means the first beat is valid in the cycle after edge k.
- Handshake:
  - A beat transfers on out_valid&&out_ready.
  - While out_valid&&!out_ready, out_word, out_mt, out_idx and out_last hold stable. No drop, no duplicate.
  - out_valid never falls without a transfer, except on reset.
- Transfer with out_last=0: idx<=idx+1.
- Transfer with out_last=1: state<=IDLE, idx<=0, line_done=1 for exactly one cycle (the cycle after the final handshake). line_ready=1 in that same cycle, so back-to-back lines incur 1 idle cycle.
- Full line: nz_cnt=LINE_SIZE (128), so CNT_WIDTH holds the value; idx never wraps past LINE_SIZE-1.
- line_valid asserted while in STREAM is not accepted; the upstream stage holds it.

Optional Feature:
- ZVC_STREAMER_STATS_EN defined: adds output ports stat_lines (32b) and stat_words (32b).
  - stat_lines increments on every accepted line, including all-zero lines.
  - stat_words increments on every beat transfer.
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package zvc_pkg holds:
  - default WORD_WIDTH, LINE_SIZE, DIST_WIDTH, MAX_LIFM_RSIZ;
  - the state encoding (IDLE=0, STREAM=1);
  - a clog2-based helper for IDX_WIDTH/CNT_WIDTH.
- Sub-module zvc_nz_prefix_count: combinational, input line, output CNT_WIDTH leading-non-zero count. It is reusable by the compressor's checkers.

Test Plan:
- Words 13,47,22 at indices 0,1,2, rest zero, out_ready=1: three beats 13/47/22 with out_idx 0/1/2, out_last only on 22, then line_done one cycle later and line_ready=1.
- All-zero line: out_valid stays 0, line_done pulses exactly once, in the cycle after accept.
- Full line with word[i]=i+1 for i=0..127: 128 beats in order, out_last at idx 127, mt entries match input.
- Line 5,9,3 with out_ready pattern 0,1,0,0,1,1: outputs stable while stalled; exactly 5,9,3 delivered with no duplicates.
- Words 5,0,9: only 5 emitted with out_last=1; 9 is never seen.
- reset_n=0 after the 2nd beat of a 10-word line: out_valid=0 and line_ready=1 after release; the next line streams from idx 0.

Source files
------------

// File: rtl/zvc_pkg.sv
// rtl/zvc_pkg.sv - shared defaults, state encoding and width helper for the ZVC line streamer
package zvc_pkg;

    localparam int ZVC_WORD_WIDTH    = 8;
    localparam int ZVC_LINE_SIZE     = 128;
    localparam int ZVC_DIST_WIDTH    = 7;
    localparam int ZVC_MAX_LIFM_RSIZ = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } zvc_state_e;

    // Bits needed to encode values 0..value-1; pass LINE_SIZE+1 to size a count.
    function automatic int zvc_clog2(input int value);
        return $clog2(value);
    endfunction

endpackage

// File: rtl/zvc_nz_prefix_count.sv
// rtl/zvc_nz_prefix_count.sv - length of the leading non-zero word run of a line
//
// Ports:
//   line_data  LINE_SIZE*WORD_WIDTH packed words, word i at [i*WORD_WIDTH +: WORD_WIDTH]
//   nz_cnt     index of the first zero word, or LINE_SIZE when no word is zero
module zvc_nz_prefix_count #(
    parameter int WORD_WIDTH = 8,
    parameter int LINE_SIZE  = 128,
    parameter int CNT_WIDTH  = 8
) (
    input  logic [LINE_SIZE*WORD_WIDTH-1:0] line_data,
    output logic [CNT_WIDTH-1:0]            nz_cnt
);

    // Scanning downwards lets the lowest-indexed zero word overwrite any
    // higher one, so no "found" flag is needed.
    always_comb begin
        nz_cnt = CNT_WIDTH'(LINE_SIZE);
        for (int i = LINE_SIZE - 1; i >= 0; i--) begin
            if (line_data[i*WORD_WIDTH +: WORD_WIDTH] == '0) begin
                nz_cnt = CNT_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/zvc_line_streamer.sv
// rtl/zvc_line_streamer.sv - serialises one zero-value-compressed line into one word per beat
//
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   line_valid/line_ready   line handshake; lifm_comp = packed words, mt_comp = mapping entries
//   out_valid/out_ready     beat handshake; out_word, out_mt, out_idx, out_last describe the beat
//   line_done               one-cycle pulse after a line is fully consumed (or an all-zero line accepted)
//   stat_lines, stat_words  accepted-line and transferred-beat counters (ZVC_STREAMER_STATS_EN only)
module zvc_line_streamer
    import zvc_pkg::*;
#(
    parameter int WORD_WIDTH    = ZVC_WORD_WIDTH,
    parameter int LINE_SIZE     = ZVC_LINE_SIZE,
    parameter int DIST_WIDTH    = ZVC_DIST_WIDTH,
    parameter int MAX_LIFM_RSIZ = ZVC_MAX_LIFM_RSIZ,
    parameter int IDX_WIDTH     = zvc_clog2(LINE_SIZE),
    parameter int CNT_WIDTH     = zvc_clog2(LINE_SIZE + 1)
) (
    input  logic                                       clk,
    input  logic                                       reset_n,
    input  logic                                       line_valid,
    output logic                                       line_ready,
    input  logic [LINE_SIZE*WORD_WIDTH-1:0]            lifm_comp,
    input  logic [LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ-1:0] mt_comp,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [WORD_WIDTH-1:0]                      out_word,
    output logic [DIST_WIDTH*MAX_LIFM_RSIZ-1:0]        out_mt,
    output logic [IDX_WIDTH-1:0]                       out_idx,
    output logic                                       out_last,
    output logic                                       line_done
`ifdef ZVC_STREAMER_STATS_EN
    ,
    output logic [31:0]                                stat_lines,
    output logic [31:0]                                stat_words
`endif
);

    localparam int MT_WIDTH = DIST_WIDTH * MAX_LIFM_RSIZ;

    zvc_state_e                     state_q, state_d;
    logic [IDX_WIDTH-1:0]           idx_q, idx_d;
    logic [CNT_WIDTH-1:0]           nz_cnt_q;
    logic [LINE_SIZE*WORD_WIDTH-1:0] line_q;
    logic [LINE_SIZE*MT_WIDTH-1:0]  mt_q;
    logic                           done_q, done_d;
    logic                           load;
    logic                           last_beat;
    logic [CNT_WIDTH-1:0]           prefix_cnt;

    zvc_nz_prefix_count #(
        .WORD_WIDTH (WORD_WIDTH),
        .LINE_SIZE  (LINE_SIZE),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_prefix (
        .line_data  (lifm_comp),
        .nz_cnt     (prefix_cnt)
    );

    // nz_cnt_q is never zero while streaming, so the subtraction cannot wrap.
    assign last_beat = (CNT_WIDTH'(idx_q) == (nz_cnt_q - CNT_WIDTH'(1)));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        load       = 1'b0;
        done_d     = 1'b0;
        line_ready = 1'b0;
        out_valid  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                line_ready = 1'b1;
                if (line_valid) begin
                    load  = 1'b1;
                    idx_d = '0;
                    if (prefix_cnt != '0) begin
                        state_d = ST_STREAM;
                    end else begin
                        // Nothing to emit: report the line consumed straight away.
                        done_d = 1'b1;
                    end
                end
            end
            ST_STREAM: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (last_beat) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx_q    <= '0;
            nz_cnt_q <= '0;
            line_q   <= '0;
            mt_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            done_q <= done_d;
            if (load) begin
                line_q   <= lifm_comp;
                mt_q     <= mt_comp;
                nz_cnt_q <= prefix_cnt;
            end
        end
    end

    // Beat fields come straight from registered state and are forced to zero
    // outside STREAM so an idle streamer shows no stale data.
    always_comb begin
        out_word = '0;
        out_mt   = '0;
        out_idx  = '0;
        out_last = 1'b0;
        if (state_q == ST_STREAM) begin
            out_word = line_q[idx_q*WORD_WIDTH +: WORD_WIDTH];
            out_mt   = mt_q[idx_q*MT_WIDTH +: MT_WIDTH];
            out_idx  = idx_q;
            out_last = last_beat;
        end
    end

    assign line_done = done_q;

`ifdef ZVC_STREAMER_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stat_lines <= '0;
            stat_words <= '0;
        end else begin
            if (load) begin
                stat_lines <= stat_lines + 32'd1;
            end
            if (out_valid && out_ready) begin
                stat_words <= stat_words + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_zvc_line_streamer.sv
// tb/tb_zvc_line_streamer.sv - scoreboard bench for zvc_line_streamer
module tb_zvc_line_streamer;

    localparam int WW = 8;
    localparam int LS = 128;
    localparam int MW = 28;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               line_valid = 1'b0;
    logic               line_ready;
    logic [LS*WW-1:0]   lifm_comp = '0;
    logic [LS*MW-1:0]   mt_comp = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [WW-1:0]      out_word;
    logic [MW-1:0]      out_mt;
    logic [6:0]         out_idx;
    logic               out_last;
    logic               line_done;
`ifdef ZVC_STREAMER_STATS_EN
    logic [31:0]        stat_lines;
    logic [31:0]        stat_words;
`endif

    zvc_line_streamer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .line_valid (line_valid),
        .line_ready (line_ready),
        .lifm_comp  (lifm_comp),
        .mt_comp    (mt_comp),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_word   (out_word),
        .out_mt     (out_mt),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .line_done  (line_done)
`ifdef ZVC_STREAMER_STATS_EN
        ,
        .stat_lines (stat_lines),
        .stat_words (stat_words)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WW-1:0] w;
        logic [MW-1:0] mt;
        int            idx;
        logic          last;
    } beat_t;

    beat_t       sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          beats_seen = 0;
    int          lines_sent = 0;
    int          rmode = 0;
    int          pat_i = 0;
    logic [5:0]  pat = 6'b110010;
    logic [WW-1:0] lw [LS];
    logic [MW-1:0] lm [LS];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Consumer ready: always 1, random, or a fixed 0,1,0,0,1,1 pattern then 1.
    always @(posedge clk) begin
        #1;
        case (rmode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: begin
                out_ready = (pat_i < 6) ? pat[pat_i] : 1'b1;
                pat_i++;
            end
        endcase
    end

    // Monitor: compares every transferred beat against the scoreboard and
    // tracks stability, first-beat latency and line_done timing.
    logic          stall_pending = 1'b0;
    logic          exp_done = 1'b0;
    logic          exp_valid = 1'b0;
    logic [WW-1:0] s_word;
    logic [MW-1:0] s_mt;
    logic [6:0]    s_idx;
    logic          s_last;

    always @(negedge clk) begin
        logic nd, nv;
        beat_t e;
        if (!reset_n) begin
            stall_pending = 1'b0;
            exp_done = 1'b0;
            exp_valid = 1'b0;
        end else begin
            if (line_done || exp_done) chk("line_done", 64'(line_done), 64'(exp_done));
            if (line_done) chk("ready_with_done", 64'(line_ready), 64'd1);
            if (exp_valid) chk("first_beat_latency", 64'(out_valid), 64'd1);
            if (out_valid) chk("no_overlap", 64'(line_ready), 64'd0);
            if (stall_pending) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_word", 64'(out_word), 64'(s_word));
                chk("stall_mt", 64'(out_mt), 64'(s_mt));
                chk("stall_idx", 64'(out_idx), 64'(s_idx));
                chk("stall_last", 64'(out_last), 64'(s_last));
            end
            nd = 1'b0;
            nv = 1'b0;
            if (line_valid && line_ready) begin
                if (lifm_comp[WW-1:0] == '0) nd = 1'b1;
                else nv = 1'b1;
            end
            stall_pending = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL extra_beat actual=word %0h idx %0d expected=no beat", out_word, out_idx);
                    end else begin
                        e = sb.pop_front();
                        chk("beat_word", 64'(out_word), 64'(e.w));
                        chk("beat_mt", 64'(out_mt), 64'(e.mt));
                        chk("beat_idx", 64'(out_idx), 64'(e.idx));
                        chk("beat_last", 64'(out_last), 64'(e.last));
                    end
                    beats_seen++;
                    if (out_last) nd = 1'b1;
                end else begin
                    stall_pending = 1'b1;
                    s_word = out_word;
                    s_mt = out_mt;
                    s_idx = out_idx;
                    s_last = out_last;
                end
            end
            exp_done = nd;
            exp_valid = nv;
        end
    end

    // Presents lw/lm as a line, holds it until accepted, and queues the
    // expected beats: the leading non-zero words, last flag on the final one.
    task automatic send_line();
        int  n;
        bit  got;
        @(posedge clk);
        #1;
        for (int i = 0; i < LS; i++) begin
            lifm_comp[i*WW +: WW] = lw[i];
            mt_comp[i*MW +: MW] = lm[i];
        end
        line_valid = 1'b1;
        got = 0;
        for (int t = 0; t < 3000 && !got; t++) begin
            @(negedge clk);
            if (line_ready && reset_n) got = 1;
        end
        if (!got) begin
            chk("accept_timeout", 64'd0, 64'd1);
        end else begin
            n = LS;
            for (int i = LS - 1; i >= 0; i--) if (lw[i] == '0) n = i;
            for (int i = 0; i < n; i++) begin
                beat_t b;
                b.w = lw[i];
                b.mt = lm[i];
                b.idx = i;
                b.last = (i == n - 1);
                sb.push_back(b);
            end
            lines_sent++;
        end
        @(posedge clk);
        #1;
        line_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok = 0;
        for (int t = 0; t < 3000 && !ok; t++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) ok = 1;
        end
        if (!ok) chk("drain_timeout", 64'(sb.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic fill_line(input int n, input bit garbage);
        for (int i = 0; i < LS; i++) begin
            lm[i] = MW'($urandom);
            if (i < n) lw[i] = WW'($urandom_range(1, 255));
            else if (i == n) lw[i] = '0;
            else lw[i] = garbage ? WW'($urandom) : '0;
        end
    endtask

    initial begin
        int base;
        bit ok;
        int n;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_line_ready", 64'(line_ready), 64'd1);
        chk("rst_line_done", 64'(line_done), 64'd0);
        chk("rst_out_word", 64'(out_word), 64'd0);
        chk("rst_out_mt", 64'(out_mt), 64'd0);
        chk("rst_out_idx", 64'(out_idx), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);

        // 13,47,22 then zeros
        fill_line(0, 0);
        lw[0] = 8'd13; lw[1] = 8'd47; lw[2] = 8'd22;
        send_line();
        drain();

        // all-zero line
        fill_line(0, 0);
        send_line();
        drain();

        // full line, word[i] = i+1
        for (int i = 0; i < LS; i++) begin
            lw[i] = WW'(i + 1);
            lm[i] = MW'($urandom);
        end
        send_line();
        drain();

        // 5,9,3 with a stalling consumer
        fill_line(0, 0);
        lw[0] = 8'd5; lw[1] = 8'd9; lw[2] = 8'd3;
        pat_i = 0;
        rmode = 2;
        send_line();
        drain();
        rmode = 0;

        // 5,0,9: only 5 is emitted
        fill_line(0, 0);
        lw[0] = 8'd5; lw[2] = 8'd9;
        send_line();
        drain();

        // reset after the 2nd beat of a 10-word line
        fill_line(10, 0);
        base = beats_seen;
        send_line();
        ok = 0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (beats_seen >= base + 2) ok = 1;
        end
        if (!ok) chk("mid_reset_wait", 64'(beats_seen - base), 64'd2);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        sb.delete();
        lines_sent = 0;
        beats_seen = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_reset_valid", 64'(out_valid), 64'd0);
        chk("post_reset_ready", 64'(line_ready), 64'd1);
        fill_line(3, 1);
        send_line();
        drain();

        // randomized back-to-back lines with a random consumer
        rmode = 1;
        for (int k = 0; k < 24; k++) begin
            case ($urandom_range(0, 5))
                0: n = 0;
                1: n = LS;
                default: n = $urandom_range(1, 24);
            endcase
            fill_line(n, 1);
            send_line();
        end
        drain();
        rmode = 0;

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
`ifdef ZVC_STREAMER_STATS_EN
        chk("stat_lines", 64'(stat_lines), 64'(lines_sent));
        chk("stat_words", 64'(stat_words), 64'(beats_seen));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=%0t expected=finish", $time);
        $fatal(1, "timeout");
    end

endmodule
